// File: rtl/btn_event_arbiter.sv
// Round-robin sequencer for per-button press events onto one valid/ready channel.
// One pending slot per button; events hitting an occupied slot are dropped and counted.
module btn_event_arbiter #(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] scen,
  input  logic [3:0] mcen,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [1:0] ev_btn,
  output logic [1:0] ev_type,
  output logic [3:0] pending,
  output logic [7:0] drop_cnt
);

  localparam int unsigned NBTN = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned DW   = 8;

  localparam logic [1:0] T_NONE   = 2'b00;
  localparam logic [1:0] T_SINGLE = 2'b01;
  localparam logic [1:0] T_REPEAT = 2'b10;

  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

  state_t                 state_q, state_d;
  logic [NBTN-1:0]        slot_occ_q, slot_occ_d;
  logic [NBTN-1:0][1:0]   slot_type_q, slot_type_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                   ev_valid_d;
  logic [1:0]             ev_btn_d, ev_type_d;
  logic [DW-1:0]          drop_cnt_d;
  logic [NBTN-1:0][1:0]   evt_c;
  logic                   accept_c;
  logic                   sel_found_c;
  logic [1:0]             sel_idx_c;
  logic [2:0]             drop_sum_c;
  logic [DW:0]            drop_ext_c;

  // Event decode: SINGLE wins when both enables fire on the first press
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      evt_c[i] = scen[i] ? T_SINGLE : (mcen[i] ? T_REPEAT : T_NONE);
    end
  end

  // First occupied slot after rr_ptr; later k overridden by earlier k
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = 2'd0;
    for (int k = NBTN; k >= 1; k--) begin
      if (slot_occ_q[2'(rr_ptr_q + 2'(k))]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = 2'(rr_ptr_q + 2'(k));
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ev_valid_d = ev_valid;
    ev_btn_d   = ev_btn;
    ev_type_d  = ev_type;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    accept_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found_c) begin
          ev_valid_d = 1'b1;
          ev_btn_d   = sel_idx_c;
          ev_type_d  = slot_type_q[sel_idx_c];
          state_d    = OFFER;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          accept_c   = 1'b1;
          rr_ptr_d   = ev_btn;
          ev_valid_d = 1'b0;
          ev_type_d  = T_NONE;
          hold_cnt_d = CW'(HOLDOFF);
          state_d    = (HOLDOFF == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - CW'(1);
        if (hold_cnt_q <= CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot load / reload / clear and drop accounting
  always_comb begin
    slot_occ_d  = slot_occ_q;
    slot_type_d = slot_type_q;
    drop_sum_c  = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (evt_c[i] != T_NONE) begin
        if (!slot_occ_q[i] || (accept_c && (ev_btn == 2'(i)))) begin
          slot_occ_d[i]  = 1'b1;
          slot_type_d[i] = evt_c[i];
        end else begin
          drop_sum_c = drop_sum_c + 3'd1;
        end
      end else if (accept_c && (ev_btn == 2'(i))) begin
        slot_occ_d[i] = 1'b0;
      end
    end
    drop_ext_c = {1'b0, drop_cnt} + (DW+1)'(drop_sum_c);
    drop_cnt_d = drop_ext_c[DW] ? {DW{1'b1}} : drop_ext_c[DW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_occ_q  <= '0;
      slot_type_q <= '0;
      rr_ptr_q    <= 2'd3;
      hold_cnt_q  <= '0;
      ev_valid    <= 1'b0;
      ev_btn      <= 2'd0;
      ev_type     <= T_NONE;
      drop_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      slot_occ_q  <= slot_occ_d;
      slot_type_q <= slot_type_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      ev_valid    <= ev_valid_d;
      ev_btn      <= ev_btn_d;
      ev_type     <= ev_type_d;
      drop_cnt    <= drop_cnt_d;
    end
  end

  assign pending = slot_occ_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_btn_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] scen, mcen;
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_btn, ev_type;
  logic [3:0] pending;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  btn_event_arbiter #(.HOLDOFF(2)) dut (
    .clk(clk), .reset(reset), .scen(scen), .mcen(mcen), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_btn(ev_btn), .ev_type(ev_type),
    .pending(pending), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] scen;
    logic [3:0] mcen;
    logic       rdy;
    logic       vld;
    logic [1:0] btn;
    logic [1:0] typ;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] s, input logic [3:0] m,
                              input logic rdy, input logic vld, input logic [1:0] btn,
                              input logic [1:0] typ, input logic [3:0] pend);
    vec_t r;
    r.rst = rst; r.scen = s; r.mcen = m; r.rdy = rdy;
    r.vld = vld; r.btn = btn; r.typ = typ; r.pend = pend;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [3:0] m, input logic r);
    scen = s; mcen = m; ev_ready = r;
  endtask

  task automatic do_reset();
    drive(4'b0, 4'b0, 1'b0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  int n;

  initial begin
    reset = 1'b1;
    drive(4'b0, 4'b0, 1'b0);

    // Columns: rst, scen, mcen, ready | expected valid, btn, type, pending (checked before driving)
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 0, 2'b00, 4'b0000)); // 0 latency pulse
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 1, 1, 2'b01, 4'b0010)); // accept + reload
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b0010));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 1, 2'b01, 4'b0010)); // 6 = accept+4
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 1, 0, 0, 2'b00, 4'b0000)); // 8 round-robin
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 0, 2'b01, 4'b1111));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1110));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1110));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1110));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 1, 2'b01, 4'b1110));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1100));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1100));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1100));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 2, 2'b01, 4'b1100));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 3, 2'b01, 4'b1000));
    vecs.push_back(mk(0, 4'b0010, 4'b1010, 1, 0, 0, 2'b00, 4'b0000)); // 23 btn1 SINGLE, btn3 REPEAT
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 1, 2'b01, 4'b1010));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b1000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 3, 2'b10, 4'b1000));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 2'b00, 4'b0000));

    step(); step();
    reset = 1'b0;
    chk("reset valid", ev_valid, 0);
    chk("reset drop_cnt", drop_cnt, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("v%0d valid", i), ev_valid, vecs[i].vld);
      if (vecs[i].vld) chk($sformatf("v%0d btn", i), ev_btn, vecs[i].btn);
      chk($sformatf("v%0d type", i), ev_type, vecs[i].typ);
      chk($sformatf("v%0d pending", i), pending, vecs[i].pend);
      reset = vecs[i].rst;
      drive(vecs[i].scen, vecs[i].mcen, vecs[i].rdy);
      step();
    end
    reset = 1'b0;
    chk("table drop_cnt", drop_cnt, 0);

    // Backpressure: held offer, three drops, then accept
    do_reset();
    drive(4'b0000, 4'b0100, 1'b0); step(); drive(4'b0, 4'b0, 1'b0);
    chk("bp pending", pending, 4'b0100);
    chk("bp valid early", ev_valid, 0);
    step();
    chk("bp offer", {ev_valid, ev_btn, ev_type}, 5'b11010);
    for (int k = 0; k < 20; k++) begin
      mcen = (k == 3 || k == 8 || k == 13) ? 4'b0100 : 4'b0000;
      step();
      chk($sformatf("bp hold %0d", k), {ev_valid, ev_btn, ev_type}, 5'b11010);
    end
    mcen = 4'b0;
    chk("bp drop_cnt", drop_cnt, 3);
    chk("bp pending held", pending, 4'b0100);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    chk("bp accepted valid", ev_valid, 0);
    chk("bp accepted type", ev_type, 0);
    chk("bp accepted pending", pending, 4'b0000);
    chk("bp drop_cnt after", drop_cnt, 3);

    // Same-edge reload: REPEAT offered, SINGLE arrives on the accept edge
    do_reset();
    drive(4'b0000, 4'b0001, 1'b0); step(); drive(4'b0, 4'b0, 1'b0); step();
    chk("reload offer", {ev_valid, ev_btn, ev_type}, 5'b10010);
    drive(4'b0001, 4'b0000, 1'b1); step(); drive(4'b0, 4'b0, 1'b1);
    chk("reload valid drop", ev_valid, 0);
    chk("reload pending", pending, 4'b0001);
    chk("reload no drop", drop_cnt, 0);
    n = 1;
    while (!ev_valid && n < 10) begin
      step();
      n++;
    end
    chk("reload gap cycles", n, 4);
    chk("reload next offer", {ev_valid, ev_btn, ev_type}, 5'b10001);

    // Reset mid-offer with button 2 pending
    do_reset();
    drive(4'b0100, 4'b0000, 1'b0); step(); drive(4'b0, 4'b0, 1'b0); step();
    chk("rst offer", {ev_valid, ev_btn, ev_type}, 5'b11001);
    drive(4'b0100, 4'b0000, 1'b0); step(); drive(4'b0, 4'b0, 1'b0);
    chk("rst pre drop", drop_cnt, 1);
    reset = 1'b1;
    #1;
    chk("rst async valid", ev_valid, 0);
    step();
    chk("rst outputs", {ev_valid, ev_btn, ev_type}, 0);
    chk("rst pending", pending, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    drive(4'b1001, 4'b0000, 1'b0); step(); drive(4'b0, 4'b0, 1'b0);
    chk("post-rst pending", pending, 4'b1001);
    step();
    chk("post-rst first offer", {ev_valid, ev_btn, ev_type}, 5'b10001);

    // Saturation: 300 drops, four per cycle
    do_reset();
    drive(4'b1111, 4'b0000, 1'b0); step();
    chk("sat no drop on load", drop_cnt, 0);
    for (int k = 0; k < 63; k++) step();
    chk("sat 252", drop_cnt, 252);
    step();
    chk("sat clamp", drop_cnt, 255);
    for (int k = 0; k < 11; k++) step();
    drive(4'b0, 4'b0, 1'b0);
    step();
    chk("sat hold", drop_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Collects per-button press events from the four pushbutton debouncers and sequences them one at a time onto a single registered valid/ready event channel feeding the game control FSM. Each button owns a one-deep pending slot. A round-robin arbiter picks the next slot to offer, and a programmable holdoff separates consecutive offers. Events that arrive while a button's slot is still occupied are dropped and counted.

## Interface
- `HOLDOFF`, default 2: idle cycles inserted after each accepted event before the next offer; 0..15 legal.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `scen`  in  4  per-button single-clock-enable pulses, bit i = button i.
- `mcen`  in  4  per-button multiple-clock-enable (auto-repeat) pulses.
- `ev_ready`  in  1  consumer accepts the offered event this cycle.
- `ev_valid`  out  1  event offered; registered.
- `ev_btn`  out  2  button index of the offered event; registered.
- `ev_type`  out  2  01 = SINGLE, 10 = REPEAT; 00 when `ev_valid` = 0.
- `pending`  out  4  occupied-slot flags, bit i = button i.
- `drop_cnt`  out  8  saturating count of dropped events.

## Operation
- Event decode per button i, each cycle:
  - `scen[i]` = 1 → SINGLE. This applies even if `mcen[i]` = 1; the debouncer raises both on the first press.
  - `mcen[i]` = 1 and `scen[i]` = 0 → REPEAT.
  - Otherwise no event.
- Slot update per button i, at the clock edge:
  - Event and slot empty → slot loads the type.
  - Event and slot occupied and not being accepted this edge → event dropped; `drop_cnt` += 1, saturating at 255.
  - Event and slot being accepted this edge → slot reloads with the new type. No drop.
  - Simultaneous drops on several buttons in one edge count once per button. Saturation still applies.
- FSM states: IDLE, OFFER, GAP.
  - IDLE: if any slot is occupied, select the first occupied button after `rr_ptr`, searching upward modulo 4. Register `ev_btn` and `ev_type` from that slot, set `ev_valid` = 1, go to OFFER. If no slot is occupied, stay in IDLE.
  - OFFER: hold `ev_valid`, `ev_btn` and `ev_type` stable while `ev_ready` = 0. When `ev_ready` = 1:
    - clear the granted slot, unless it reloads as described above;
    - set `rr_ptr` to `ev_btn`;
    - drop `ev_valid` next cycle;
    - load the holdoff counter with `HOLDOFF` and go to GAP, or go to IDLE when `HOLDOFF` = 0.
  - GAP: decrement the counter. When the counter reaches 1, go to IDLE.
- An offered event's `ev_type` is frozen at offer time. A slot reload while in OFFER is impossible by construction, because the slot is occupied and new events to it drop.
- `pending` mirrors slot occupancy, registered.

## Timing
- Reset values: FSM = IDLE, all slots empty, `rr_ptr` = 3 (button 0 has first priority), `ev_valid` = 0, `ev_btn` = 0, `ev_type` = 00, `pending` = 0, `drop_cnt` = 0, holdoff counter = 0.
- Reset asserted mid-offer or mid-GAP: everything returns to reset values. The consumer sees `ev_valid` fall asynchronously.
- Latency with the FSM idle: input pulse in cycle t → `pending[i]` = 1 in t+1 → `ev_valid` = 1 in t+2.
- Accept in cycle a (`ev_valid` & `ev_ready`) → `ev_valid` = 0 in a+1. With the FSM in GAP, the earliest next `ev_valid` is in cycle a+HOLDOFF+2. With `HOLDOFF` = 0, that is cycle a+2.
- Maximum sustained throughput is one event per HOLDOFF+2 cycles.
- `ev_ready` while `ev_valid` = 0 is ignored.

## Test plan
- Reset check: assert `reset` mid-OFFER with button 2 pending → next cycle all outputs are 0, `pending` = 0000, and the FSM is IDLE.
- Latency: pulse `scen[1]` in cycle 10 with `ev_ready` = 1 held → `pending` = 0010 at 11; `ev_valid` = 1, `ev_btn` = 1, `ev_type` = 01 at 12; `ev_valid` = 0 at 13. With `HOLDOFF` = 2, a second `scen[1]` pulse in cycle 12 is offered at 16.
- Round-robin: pulse `scen` = 1111 in one cycle with `ev_ready` = 1 → `ev_btn` order 0,1,2,3. Then, with `rr_ptr` = 3, pulse buttons 1 and 3 together → order 1,3.
- Backpressure and drop: `ev_ready` = 0. Pulse `mcen[2]` → offer btn 2, type 10, held stable for 20 cycles. Three further `mcen[2]` pulses → `drop_cnt` = 3. Assert `ev_ready` → accepted, `pending[2]` = 0.
- Same-edge reload: a `scen[0]` pulse coincides with acceptance of button 0 → no drop, `pending[0]` stays 1, and the next offer is btn 0, type 01.
- Saturation: 300 dropped events → `drop_cnt` = 255 and stays there.
